// File: rtl/sctr_bus_mux.sv
// sctr address-decoding bus mux: routes one outstanding command to a slave,
// returns its response, and turns unmapped/timed-out accesses into errors.
module sctr_bus_mux #(
    parameter int SLV_NUM = 4,
    parameter int SEL_LSB = 28,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            m_cmd_addr,
    input  logic [31:0]            m_cmd_wdata,
    input  logic                   m_cmd_we,
    input  logic [3:0]             m_cmd_wem,
    input  logic                   m_cmd_valid,
    output logic                   m_cmd_ready,
    output logic [31:0]            m_rsp_rdata,
    output logic                   m_rsp_error,
    output logic                   m_rsp_valid,
    input  logic                   m_rsp_ready,
    output logic [31:0]            s_cmd_addr,
    output logic [31:0]            s_cmd_wdata,
    output logic                   s_cmd_we,
    output logic [3:0]             s_cmd_wem,
    output logic [SLV_NUM-1:0]     s_cmd_valid,
    input  logic [SLV_NUM-1:0]     s_cmd_ready,
    input  logic [32*SLV_NUM-1:0]  s_rsp_rdata,
    input  logic [SLV_NUM-1:0]     s_rsp_error,
    input  logic [SLV_NUM-1:0]     s_rsp_valid,
    output logic [SLV_NUM-1:0]     s_rsp_ready,
    output logic                   busy_o,
    output logic                   timeout_o
);

    localparam int IW = 32 - SEL_LSB;
    localparam int SW = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR
    } state_t;

    state_t state;
    logic [SW-1:0] sel;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          cnt_last;

    logic [IW-1:0]      idx;
    logic [SLV_NUM-1:0] hit;
    logic [SW-1:0]      hit_idx;
    logic               mapped;
    logic [SLV_NUM-1:0] sel_oh;

    logic        sel_valid;
    logic        sel_error;
    logic [31:0] sel_rdata;
    logic        cmd_hs;
    logic        rsp_hs;

    assign s_cmd_addr  = m_cmd_addr;
    assign s_cmd_wdata = m_cmd_wdata;
    assign s_cmd_we    = m_cmd_we;
    assign s_cmd_wem   = m_cmd_wem;

    assign idx    = m_cmd_addr[31:SEL_LSB];
    assign busy_o = (state != S_IDLE);

    // one-hot views of the incoming decode and the latched selection
    always_comb begin
        hit     = '0;
        hit_idx = '0;
        sel_oh  = '0;
        for (int i = 0; i < SLV_NUM; i++) begin
            if (idx == IW'(i)) begin
                hit[i]  = 1'b1;
                hit_idx = SW'(i);
            end
            if (sel == SW'(i)) begin
                sel_oh[i] = 1'b1;
            end
        end
        mapped = |hit;
    end

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < SLV_NUM; i++) begin
            if (sel_oh[i]) begin
                sel_rdata = s_rsp_rdata[32*i +: 32];
            end
        end
        sel_valid = |(s_rsp_valid & sel_oh);
        sel_error = |(s_rsp_error & sel_oh);
    end

    always_comb begin
        s_cmd_valid = '0;
        s_rsp_ready = '1;
        m_cmd_ready = 1'b0;
        m_rsp_valid = 1'b0;
        m_rsp_rdata = '0;
        m_rsp_error = 1'b0;
        unique case (state)
            S_IDLE: begin
                s_cmd_valid = hit & {SLV_NUM{m_cmd_valid}};
                m_cmd_ready = mapped ? |(hit & s_cmd_ready) : 1'b1;
            end
            S_WAIT: begin
                m_rsp_valid = sel_valid;
                m_rsp_rdata = sel_rdata;
                m_rsp_error = sel_error;
                // non-selected slaves are drained so stray responses drop
                s_rsp_ready = ~sel_oh | ({SLV_NUM{m_rsp_ready}} & sel_oh);
            end
            S_ERR: begin
                m_rsp_valid = 1'b1;
                m_rsp_error = 1'b1;
            end
            default: ;
        endcase
    end

    assign cmd_hs   = m_cmd_valid & m_cmd_ready;
    assign rsp_hs   = m_rsp_valid & m_rsp_ready;
    assign cnt_inc  = cnt + CW'(1);
    assign cnt_last = (cnt_inc == CW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sel       <= '0;
            cnt       <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (cmd_hs) begin
                        if (mapped) begin
                            sel   <= hit_idx;
                            cnt   <= '0;
                            state <= S_WAIT;
                        end else begin
                            state <= S_ERR;
                        end
                    end
                end
                S_WAIT: begin
                    // a valid response, even stalled, never counts
                    if (sel_valid) begin
                        if (rsp_hs) begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_last) begin
                            timeout_o <= 1'b1;
                            state     <= S_ERR;
                        end
                    end
                end
                S_ERR: begin
                    if (rsp_hs) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sctr_bus_mux.sv
// Directed bench for sctr_bus_mux: each step drives the slave/master pins
// and checks hand-computed responses with immediate assertions.
module tb_sctr_bus_mux;

    logic         clk;
    logic         rst_n;
    logic [31:0]  m_cmd_addr;
    logic [31:0]  m_cmd_wdata;
    logic         m_cmd_we;
    logic [3:0]   m_cmd_wem;
    logic         m_cmd_valid;
    logic         m_cmd_ready;
    logic [31:0]  m_rsp_rdata;
    logic         m_rsp_error;
    logic         m_rsp_valid;
    logic         m_rsp_ready;
    logic [31:0]  s_cmd_addr;
    logic [31:0]  s_cmd_wdata;
    logic         s_cmd_we;
    logic [3:0]   s_cmd_wem;
    logic [3:0]   s_cmd_valid;
    logic [3:0]   s_cmd_ready;
    logic [127:0] s_rsp_rdata;
    logic [3:0]   s_rsp_error;
    logic [3:0]   s_rsp_valid;
    logic [3:0]   s_rsp_ready;
    logic         busy_o;
    logic         timeout_o;

    int checks;
    int failures;
    int bad;

    sctr_bus_mux dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_cmd_addr  (m_cmd_addr),
        .m_cmd_wdata (m_cmd_wdata),
        .m_cmd_we    (m_cmd_we),
        .m_cmd_wem   (m_cmd_wem),
        .m_cmd_valid (m_cmd_valid),
        .m_cmd_ready (m_cmd_ready),
        .m_rsp_rdata (m_rsp_rdata),
        .m_rsp_error (m_rsp_error),
        .m_rsp_valid (m_rsp_valid),
        .m_rsp_ready (m_rsp_ready),
        .s_cmd_addr  (s_cmd_addr),
        .s_cmd_wdata (s_cmd_wdata),
        .s_cmd_we    (s_cmd_we),
        .s_cmd_wem   (s_cmd_wem),
        .s_cmd_valid (s_cmd_valid),
        .s_cmd_ready (s_cmd_ready),
        .s_rsp_rdata (s_rsp_rdata),
        .s_rsp_error (s_rsp_error),
        .s_rsp_valid (s_rsp_valid),
        .s_rsp_ready (s_rsp_ready),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        m_cmd_addr  = 32'h0;
        m_cmd_wdata = 32'h0;
        m_cmd_we    = 1'b0;
        m_cmd_wem   = 4'h0;
        m_cmd_valid = 1'b0;
        m_rsp_ready = 1'b1;
        s_cmd_ready = 4'h0;
        s_rsp_rdata = '0;
        s_rsp_error = 4'h0;
        s_rsp_valid = 4'h0;
        tick();
        tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_rsp_valid", m_rsp_valid, 0);
        chk("rst_s_rsp_ready", s_rsp_ready, 4'hF);
        rst_n = 1'b1;

        // read slave 1, response on third WAIT cycle
        m_cmd_addr  = 32'h1000_0010;
        m_cmd_wdata = 32'hA5A5_0001;
        m_cmd_wem   = 4'h3;
        m_cmd_valid = 1'b1;
        s_cmd_ready = 4'b0010;
        #1;
        chk("t1_s_cmd_valid", s_cmd_valid, 4'b0010);
        chk("t1_cmd_ready", m_cmd_ready, 1);
        chk("t1_bcast_addr", s_cmd_addr, 32'h1000_0010);
        chk("t1_bcast_wdata", s_cmd_wdata, 32'hA5A5_0001);
        chk("t1_bcast_wem", s_cmd_wem, 4'h3);
        tick();
        m_cmd_valid = 1'b0;
        #1;
        chk("t1_busy_c1", busy_o, 1);
        chk("t1_cmd_ready_wait", m_cmd_ready, 0);
        chk("t1_rsp_valid_c1", m_rsp_valid, 0);
        tick();
        chk("t1_busy_c2", busy_o, 1);
        tick();
        s_rsp_valid = 4'b0010;
        s_rsp_rdata[31:0]  = 32'h1111_1111;
        s_rsp_rdata[63:32] = 32'hDEAD_BEEF;
        #1;
        chk("t1_busy_c3", busy_o, 1);
        chk("t1_rsp_valid", m_rsp_valid, 1);
        chk("t1_rdata", m_rsp_rdata, 32'hDEAD_BEEF);
        chk("t1_error", m_rsp_error, 0);
        chk("t1_s_rsp_ready", s_rsp_ready, 4'hF);
        tick();
        s_rsp_valid = 4'h0;
        #1;
        chk("t1_idle", busy_o, 0);

        // unmapped write
        m_cmd_addr  = 32'h7000_0000;
        m_cmd_we    = 1'b1;
        m_cmd_wem   = 4'hF;
        m_cmd_valid = 1'b1;
        s_cmd_ready = 4'h0;
        #1;
        chk("t2_cmd_ready", m_cmd_ready, 1);
        chk("t2_s_cmd_valid", s_cmd_valid, 4'h0);
        chk("t2_bcast_we", s_cmd_we, 1);
        tick();
        m_cmd_valid = 1'b0;
        #1;
        chk("t2_rsp_valid", m_rsp_valid, 1);
        chk("t2_error", m_rsp_error, 1);
        chk("t2_rdata", m_rsp_rdata, 32'h0);
        chk("t2_cmd_ready_err", m_cmd_ready, 0);
        tick();
        chk("t2_idle", busy_o, 0);
        chk("t2_rsp_valid_idle", m_rsp_valid, 0);

        // slave 2 never responds -> timeout after 255 WAIT cycles
        m_cmd_addr  = 32'h2000_0040;
        m_cmd_we    = 1'b0;
        m_cmd_valid = 1'b1;
        s_cmd_ready = 4'b0100;
        #1;
        chk("t3_s_cmd_valid", s_cmd_valid, 4'b0100);
        tick();
        m_cmd_valid = 1'b0;
        bad = 0;
        repeat (254) begin
            if (timeout_o !== 1'b0 || busy_o !== 1'b1) bad++;
            tick();
        end
        chk("t3_no_early_timeout", bad, 0);
        chk("t3_c255_timeout", timeout_o, 0);
        chk("t3_c255_rsp_valid", m_rsp_valid, 0);
        tick();
        chk("t3_timeout_pulse", timeout_o, 1);
        chk("t3_err_valid", m_rsp_valid, 1);
        chk("t3_err_error", m_rsp_error, 1);
        chk("t3_err_rdata", m_rsp_rdata, 32'h0);
        tick();
        chk("t3_timeout_clear", timeout_o, 0);
        chk("t3_idle", busy_o, 0);
        repeat (9) tick();
        s_rsp_valid = 4'b0100;
        s_rsp_rdata[95:64] = 32'hBADD_0002;
        #1;
        chk("t3_late_drain", s_rsp_ready[2], 1);
        chk("t3_late_rsp_valid", m_rsp_valid, 0);
        tick();
        s_rsp_valid = 4'h0;

        // slave 0 response stalled by master for 300 cycles
        m_cmd_addr  = 32'h0000_0004;
        m_cmd_valid = 1'b1;
        s_cmd_ready = 4'b0001;
        tick();
        m_cmd_valid = 1'b0;
        m_rsp_ready = 1'b0;
        s_rsp_valid = 4'b0001;
        s_rsp_rdata[31:0] = 32'hCAFE_0001;
        #1;
        chk("t4_rsp_valid", m_rsp_valid, 1);
        chk("t4_s_rsp_ready", s_rsp_ready, 4'b1110);
        bad = 0;
        repeat (300) begin
            tick();
            if (timeout_o !== 1'b0 || m_rsp_valid !== 1'b1) bad++;
        end
        chk("t4_held", bad, 0);
        m_rsp_ready = 1'b1;
        #1;
        chk("t4_rdata", m_rsp_rdata, 32'hCAFE_0001);
        chk("t4_s_rsp_ready_hs", s_rsp_ready, 4'hF);
        tick();
        s_rsp_valid = 4'h0;
        #1;
        chk("t4_idle", busy_o, 0);
        chk("t4_no_timeout", timeout_o, 0);

        // reset in the middle of WAIT
        m_cmd_addr  = 32'h1000_0000;
        m_cmd_valid = 1'b1;
        s_cmd_ready = 4'b0010;
        tick();
        m_cmd_valid = 1'b0;
        #1;
        chk("t5_busy_pre", busy_o, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_cmd_addr  = 32'h3000_0000;
        m_cmd_valid = 1'b1;
        s_cmd_ready = 4'b0000;
        #1;
        chk("t5_busy_post", busy_o, 0);
        chk("t5_cmd_ready_nr", m_cmd_ready, 0);
        s_cmd_ready = 4'b1000;
        #1;
        chk("t5_cmd_ready", m_cmd_ready, 1);
        chk("t5_s_cmd_valid", s_cmd_valid, 4'b1000);
        tick();
        m_cmd_valid = 1'b0;
        s_rsp_valid = 4'b1000;
        s_rsp_rdata[127:96] = 32'h3333_AAAA;
        #1;
        chk("t5_rdata", m_rsp_rdata, 32'h3333_AAAA);
        chk("t5_rsp_valid", m_rsp_valid, 1);
        tick();
        s_rsp_valid = 4'h0;
        #1;
        chk("t5_idle", busy_o, 0);

        // back-to-back slave 0 then slave 3
        m_cmd_addr  = 32'h0000_0100;
        m_cmd_valid = 1'b1;
        s_cmd_ready = 4'b1001;
        tick();
        m_cmd_addr  = 32'h3000_0008;
        s_rsp_valid = 4'b0001;
        s_rsp_rdata[31:0] = 32'h0BAD_F00D;
        #1;
        chk("t6_first_rsp", m_rsp_rdata, 32'h0BAD_F00D);
        chk("t6_cmd_blocked", m_cmd_ready, 0);
        chk("t6_s_cmd_blocked", s_cmd_valid, 4'h0);
        tick();
        s_rsp_valid = 4'h0;
        #1;
        chk("t6_second_hs", m_cmd_ready, 1);
        chk("t6_second_valid", s_cmd_valid, 4'b1000);
        tick();
        m_cmd_valid = 1'b0;
        s_rsp_valid = 4'b1000;
        s_rsp_error = 4'b1000;
        s_rsp_rdata[127:96] = 32'h5555_0003;
        #1;
        chk("t6_busy", busy_o, 1);
        chk("t6_rdata", m_rsp_rdata, 32'h5555_0003);
        chk("t6_slave_error", m_rsp_error, 1);
        tick();
        s_rsp_valid = 4'h0;
        s_rsp_error = 4'h0;

        // response arriving on the last WAIT cycle beats the timeout
        m_cmd_addr  = 32'h1000_0020;
        m_cmd_valid = 1'b1;
        s_cmd_ready = 4'b0010;
        tick();
        m_cmd_valid = 1'b0;
        repeat (254) tick();
        s_rsp_valid = 4'b0010;
        s_rsp_rdata[63:32] = 32'h600D_0255;
        #1;
        chk("t7_rsp_valid", m_rsp_valid, 1);
        chk("t7_error", m_rsp_error, 0);
        chk("t7_rdata", m_rsp_rdata, 32'h600D_0255);
        tick();
        s_rsp_valid = 4'h0;
        #1;
        chk("t7_no_timeout", timeout_o, 0);
        chk("t7_idle", busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
